iqe_fill: RTL and testbench
===========================

Name: iqe_fill

Overview:
- Producer (write-side front end) for the dual-thread instruction-queue extra-data FIFO.
- Accepts per-thread decoded bundles of up to 4 lanes with a sparse valid mask, compacts them top-aligned, and holds them per thread.
- Arbitrates between the two threads and drives write_wen, write_thread, write_cnt, write_start and write_data0..3, honouring the queue's fStall/doFStall back-pressure and per-thread exception flush.

Parameters:
- DATA_WIDTH, `instrQExtra_width, width of one lane payload.
- LANES, 4, lanes per bundle (fixed; other values unsupported).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- except  in  1  flush request
- except_thread  in  1  thread being flushed
- in_valid  in  1  upstream bundle valid
- in_ready  out  1  bundle accepted when in_valid&in_ready
- in_thread  in  1  thread of bundle
- in_mask  in  4  lane valid mask, may be sparse
- in_data0..in_data3  in  DATA_WIDTH  lane payloads
- fStall  in  1  front-end stall
- doFStall  in  1  queue-near-full stall
- write_wen  out  1  write request
- write_thread  out  1  thread of write
- write_cnt  out  5  one-hot entry count, bit n = n entries
- write_start  out  5  one-hot first valid lane = 4-n (n=0 -> bit4)
- write_data0..write_data3  out  DATA_WIDTH  top-aligned compacted lanes

Behaviour:
- State:
  - per-thread holding slot: hold_v, compacted data, count n.
  - round-robin pointer rr.
- Capture:
  - on accept, the k-th set bit of in_mask (ascending, k=0..n-1) goes to lane 4-n+k; unused lanes are zero.
  - hold_v[in_thread] <= (n!=0); mask=0 is accepted and dropped.
- in_ready = ~hold_v[in_thread] | drain[in_thread]. Combinational; no dependence on in_valid.
- Output (registered-slot, default build):
  - write_wen = |hold_v & ~(except & except_thread==write_thread).
  - write_thread = selected slot; remaining outputs are taken from the selected slot.
  - selection: if exactly one slot is valid, use it; if both are valid, use thread rr.
- Drain:
  - drain = write_wen & ~fStall & ~doFStall.
  - on drain, clear hold_v[write_thread] and set rr <= ~write_thread.
  - without drain, all outputs are held stable. No change is allowed while stalled.
- Latency: bundle accepted at cycle N -> earliest write_wen at N+1; throughput 1 bundle/cycle per drain.
- Simultaneous drain and capture for the same thread: the new bundle overwrites the slot (in_ready=1).
- Except:
  - clears hold_v[except_thread] and drops any same-cycle capture for except_thread.
  - the other thread's slot and rr are unaffected.
  - if except wins over a drain of the same thread, rr is not updated.
- Reset:
  - hold_v=0, rr=0, write_wen=0, write_cnt=5'b00001, write_start=5'b10000, write_data*=0, write_thread=0.
  - in_ready=1.
  - reset mid-stall discards both slots.
- Invariant: write_cnt and write_start are always one-hot with write_start = bit(4-n) for write_cnt = bit(n). When write_wen=0, they show the idle values 00001 and 10000.

Optional Feature:
- IQE_FILL_BYPASS_EN defined:
  - condition: in_valid, n!=0, both slots empty, no except for in_thread, and ~fStall & ~doFStall.
  - then the compacted input drives the write_* outputs in the same cycle with write_wen=1, and the slot is not written (zero latency).
  - rr updates as for a drain.
- Undefined: strict registered path, minimum latency 1 cycle.

Decomposition:
- Shared package:
  - IQE_LANES=4.
  - typedef of the 5-bit one-hot count.
  - function count->one-hot start (bit 4-n).
  - typedef of the slot struct {valid, cnt, data[4]}.
- Sub-module iqe_compact4: combinational mask compaction to top-aligned lanes, plus the count. Instantiated once, on the input path.

Test Plan:
- Reset:
  - assert rst 2 cycles -> write_wen=0, write_cnt=00001, write_start=10000, in_ready=1.
- Sparse capture:
  - thread0, mask 1011, data A,B,C,D -> next cycle write_wen=1, thread0, cnt=01000, start=00010.
  - write_data1=A, write_data2=B, write_data3=D, write_data0=0.
- Back-pressure:
  - thread0 slot full, doFStall=1 for 3 cycles, a second thread0 bundle offered -> in_ready=0 and outputs stable.
  - drop doFStall -> drain, in_ready=1, second bundle written next cycle.
- Arbitration:
  - both slots filled after reset, no stall -> writes in order thread0 then thread1.
  - refill both -> thread0 again (rr alternates).
- Flush:
  - except with except_thread=1 while the output is showing thread1 and thread0 is also held -> write_wen=0 that cycle.
  - next cycle thread0 is written; thread1's data is never written.
- Empty bundle:
  - mask 0000 on thread1 -> accepted (in_ready=1), no write_wen, hold_v[1] stays 0.

Source files
------------

// File: rtl/iqe_fill_pkg.sv
// Shared types and helpers for the instruction-queue extra-data fill path.
// Lane payload width is the instruction-queue extra-data width.
package iqe_fill_pkg;

  localparam int IQE_LANES = 4;

  localparam int IQE_DATA_WIDTH = 16;

  // One-hot entry count: bit n set means n valid entries (0..4).
  typedef logic [IQE_LANES:0] iqe_onehot_t;

  localparam iqe_onehot_t IQE_IDLE_CNT = iqe_onehot_t'(1);

  typedef struct packed {
    logic                                      valid;
    iqe_onehot_t                               cnt;
    logic [IQE_LANES-1:0][IQE_DATA_WIDTH-1:0]  data;
  } iqe_slot_t;

  function automatic iqe_onehot_t iqe_cnt_onehot(input logic [2:0] n);
    return iqe_onehot_t'(1) << n;
  endfunction

  // First valid lane of a top-aligned bundle is 4-n, so start is cnt bit-reversed.
  function automatic iqe_onehot_t iqe_start_of(input iqe_onehot_t cnt);
    iqe_onehot_t s;
    for (int i = 0; i <= IQE_LANES; i++) s[IQE_LANES-i] = cnt[i];
    return s;
  endfunction

endpackage

// File: rtl/iqe_fill_if.sv
// Upstream bundle handshake plus queue write bus for iqe_fill.
// master = the fill block (drives in_ready and write_*), slave = its surroundings.
interface iqe_fill_if #(
  parameter int DATA_WIDTH = iqe_fill_pkg::IQE_DATA_WIDTH
);
  logic                  except;
  logic                  except_thread;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_thread;
  logic [3:0]            in_mask;
  logic [DATA_WIDTH-1:0] in_data0;
  logic [DATA_WIDTH-1:0] in_data1;
  logic [DATA_WIDTH-1:0] in_data2;
  logic [DATA_WIDTH-1:0] in_data3;
  logic                  fStall;
  logic                  doFStall;
  logic                  write_wen;
  logic                  write_thread;
  logic [4:0]            write_cnt;
  logic [4:0]            write_start;
  logic [DATA_WIDTH-1:0] write_data0;
  logic [DATA_WIDTH-1:0] write_data1;
  logic [DATA_WIDTH-1:0] write_data2;
  logic [DATA_WIDTH-1:0] write_data3;

  modport master (
    input  except, except_thread, in_valid, in_thread, in_mask,
           in_data0, in_data1, in_data2, in_data3, fStall, doFStall,
    output in_ready, write_wen, write_thread, write_cnt, write_start,
           write_data0, write_data1, write_data2, write_data3
  );

  modport slave (
    output except, except_thread, in_valid, in_thread, in_mask,
           in_data0, in_data1, in_data2, in_data3, fStall, doFStall,
    input  in_ready, write_wen, write_thread, write_cnt, write_start,
           write_data0, write_data1, write_data2, write_data3
  );
endinterface

// File: rtl/iqe_fill_compact4.sv
// Combinational compaction of a sparse 4-lane bundle into top-aligned lanes.
// The k-th set mask bit (ascending) lands in lane 4-n+k; unused lanes are zero.
module iqe_compact4
  import iqe_fill_pkg::*;
#(
  parameter int DATA_WIDTH = IQE_DATA_WIDTH
) (
  input  logic [IQE_LANES-1:0]                 mask,
  input  logic [IQE_LANES-1:0][DATA_WIDTH-1:0] din,
  output logic [IQE_LANES-1:0][DATA_WIDTH-1:0] dout,
  output logic [2:0]                           cnt
);

  logic [2:0] pos;

  always_comb begin
    cnt  = 3'd0;
    dout = '0;
    for (int i = 0; i < IQE_LANES; i++) cnt = cnt + 3'(mask[i]);
    pos = 3'd4 - cnt;
    for (int i = 0; i < IQE_LANES; i++) begin
      if (mask[i]) begin
        dout[pos[1:0]] = din[i];
        pos            = pos + 3'd1;
      end
    end
  end

endmodule

// File: rtl/iqe_fill.sv
// Dual-thread write-side producer for the instruction-queue extra-data FIFO.
// Optional zero-latency path enabled by defining IQE_FILL_BYPASS_EN.
module iqe_fill
  import iqe_fill_pkg::*;
#(
  parameter int DATA_WIDTH = IQE_DATA_WIDTH
) (
  input logic        clk,
  input logic        rst,
  iqe_fill_if.master bus
);

  if (DATA_WIDTH != IQE_DATA_WIDTH) begin : g_width_chk
    $error("iqe_fill: DATA_WIDTH must equal iqe_fill_pkg::IQE_DATA_WIDTH");
  end

  logic [IQE_LANES-1:0][DATA_WIDTH-1:0] cmp_data_p0;
  logic [2:0]                           cmp_n_p0;

  iqe_slot_t   slot_p1 [2];
  logic        rr_p1;

  logic        stall;
  logic        any_vld;
  logic        sel;
  logic        reg_wen;
  logic        drain;
  logic        accept;
  logic        byp;
  logic        out_wen;
  logic        out_thread;
  iqe_onehot_t out_cnt;
  logic [IQE_LANES-1:0][DATA_WIDTH-1:0] out_data;

  // ---- stage p0: compaction of the incoming bundle ----
  iqe_compact4 #(.DATA_WIDTH(DATA_WIDTH)) u_compact (
    .mask (bus.in_mask),
    .din  ({bus.in_data3, bus.in_data2, bus.in_data1, bus.in_data0}),
    .dout (cmp_data_p0),
    .cnt  (cmp_n_p0)
  );

  assign stall   = bus.fStall | bus.doFStall;
  assign any_vld = slot_p1[0].valid | slot_p1[1].valid;
  // Both full -> round robin; otherwise whichever is full (thread0 when idle).
  assign sel     = (slot_p1[0].valid & slot_p1[1].valid) ? rr_p1 : slot_p1[1].valid;
  assign reg_wen = any_vld & ~(bus.except & (bus.except_thread == sel));
  assign drain   = reg_wen & ~stall;

  // Depends only on slot state and drain, never on in_valid.
  assign bus.in_ready = ~slot_p1[bus.in_thread].valid | (drain & (sel == bus.in_thread));
  assign accept       = bus.in_valid & bus.in_ready;

`ifdef IQE_FILL_BYPASS_EN
  assign byp = bus.in_valid & (cmp_n_p0 != 3'd0) & ~any_vld & ~stall &
               ~(bus.except & (bus.except_thread == bus.in_thread));
`else
  assign byp = 1'b0;
`endif

  // ---- stage p1: per-thread holding slots and round-robin pointer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_p1[0].valid <= 1'b0;
      slot_p1[1].valid <= 1'b0;
      rr_p1            <= 1'b0;
    end else begin
      for (int t = 0; t < 2; t++) begin
        if (bus.except && (bus.except_thread == 1'(t))) begin
          slot_p1[t].valid <= 1'b0;
        end else if (accept && (bus.in_thread == 1'(t)) && !byp) begin
          slot_p1[t].valid <= (cmp_n_p0 != 3'd0);
          slot_p1[t].cnt   <= iqe_cnt_onehot(cmp_n_p0);
          slot_p1[t].data  <= cmp_data_p0;
        end else if (drain && (sel == 1'(t))) begin
          slot_p1[t].valid <= 1'b0;
        end
      end
      if (drain)    rr_p1 <= ~sel;
      else if (byp) rr_p1 <= ~bus.in_thread;
    end
  end

  // ---- write bus: idle encoding whenever no write is offered ----
  always_comb begin
    out_wen    = 1'b0;
    out_thread = sel;
    out_cnt    = IQE_IDLE_CNT;
    out_data   = '0;
    if (byp) begin
      out_wen    = 1'b1;
      out_thread = bus.in_thread;
      out_cnt    = iqe_cnt_onehot(cmp_n_p0);
      out_data   = cmp_data_p0;
    end else if (reg_wen) begin
      out_wen    = 1'b1;
      out_cnt    = slot_p1[sel].cnt;
      out_data   = slot_p1[sel].data;
    end
  end

  assign bus.write_wen    = out_wen;
  assign bus.write_thread = out_thread;
  assign bus.write_cnt    = out_cnt;
  assign bus.write_start  = iqe_start_of(out_cnt);
  assign bus.write_data0  = out_data[0];
  assign bus.write_data1  = out_data[1];
  assign bus.write_data2  = out_data[2];
  assign bus.write_data3  = out_data[3];

endmodule

// File: tb/tb_iqe_fill.sv
// Self-checking bench for iqe_fill: directed scenarios plus a randomized run
// against a slot-level reference model of the fill/arbitration rules.
module tb_iqe_fill;
  import iqe_fill_pkg::*;

  localparam int DW = IQE_DATA_WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iqe_fill_if #(.DATA_WIDTH(DW)) bus ();

  iqe_fill #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // stimulus for the current cycle
  bit          b_v, b_thr, b_fs, b_dfs, b_ex, b_exthr, b_rst;
  logic [3:0]  b_m;
  logic [DW-1:0] b_d [4];

  // reference model state
  bit          m_v [2];
  int          m_n [2];
  logic [DW-1:0] m_data [2][4];
  bit          m_rr;

  // per-cycle model expectations
  bit          e_wen, e_thr, e_ready, e_drain, e_byp;
  bit          e_sel;
  logic [4:0]  e_cnt, e_start;
  logic [DW-1:0] e_d [4];
  int          c_n;
  logic [DW-1:0] c_o [4];

  function automatic void compact(input logic [3:0] m, input logic [DW-1:0] d [4],
                                  output int n, output logic [DW-1:0] o [4]);
    int k;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      o[i] = '0;
      if (m[i]) n++;
    end
    k = 4 - n;
    for (int i = 0; i < 4; i++) if (m[i]) begin o[k] = d[i]; k++; end
  endfunction

  function automatic void model_expect();
    bit any;
    int n;
    any     = m_v[0] || m_v[1];
    e_sel   = (m_v[0] && m_v[1]) ? m_rr : m_v[1];
    e_wen   = any && !(b_ex && (b_exthr == e_sel));
    e_thr   = e_sel;
    e_drain = e_wen && !b_fs && !b_dfs;
    e_ready = !m_v[b_thr] || (e_drain && (e_sel == b_thr));
    compact(b_m, b_d, c_n, c_o);
    e_byp = 1'b0;
`ifdef IQE_FILL_BYPASS_EN
    e_byp = b_v && (c_n != 0) && !any && !(b_ex && (b_exthr == b_thr)) && !b_fs && !b_dfs;
`endif
    n = 0;
    for (int i = 0; i < 4; i++) e_d[i] = '0;
    if (e_byp) begin
      e_wen = 1'b1; e_thr = b_thr; n = c_n;
      for (int i = 0; i < 4; i++) e_d[i] = c_o[i];
    end else if (e_wen) begin
      n = m_n[e_sel];
      for (int i = 0; i < 4; i++) e_d[i] = m_data[e_sel][i];
    end
    e_cnt   = 5'(1 << n);
    e_start = 5'(1 << (4 - n));
  endfunction

  function automatic void model_update();
    bit accept;
    if (b_rst) begin
      m_v[0] = 1'b0; m_v[1] = 1'b0; m_rr = 1'b0;
      return;
    end
    accept = b_v && e_ready;
    for (int t = 0; t < 2; t++) begin
      if (b_ex && (b_exthr == t[0])) m_v[t] = 1'b0;
      else if (accept && (b_thr == t[0]) && !e_byp) begin
        m_v[t] = (c_n != 0);
        m_n[t] = c_n;
        for (int i = 0; i < 4; i++) m_data[t][i] = c_o[i];
      end else if (e_drain && (e_sel == t[0])) m_v[t] = 1'b0;
    end
    if (e_drain)    m_rr = !e_sel;
    else if (e_byp) m_rr = !b_thr;
  endfunction

  task automatic drive();
    @(negedge clk);
    rst               = b_rst;
    bus.in_valid      = b_v;
    bus.in_thread     = b_thr;
    bus.in_mask       = b_m;
    bus.in_data0      = b_d[0];
    bus.in_data1      = b_d[1];
    bus.in_data2      = b_d[2];
    bus.in_data3      = b_d[3];
    bus.fStall        = b_fs;
    bus.doFStall      = b_dfs;
    bus.except        = b_ex;
    bus.except_thread = b_exthr;
    #1;
    model_expect();
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_update();
  endtask

  task automatic idle_inputs();
    b_v = 0; b_thr = 0; b_m = 4'b0000; b_fs = 0; b_dfs = 0;
    b_ex = 0; b_exthr = 0; b_rst = 0;
    for (int i = 0; i < 4; i++) b_d[i] = DW'($urandom);
  endtask

  task automatic offer(input bit thr, input logic [3:0] m, input logic [DW-1:0] d3,
                       input logic [DW-1:0] d2, input logic [DW-1:0] d1, input logic [DW-1:0] d0);
    b_v = 1; b_thr = thr; b_m = m;
    b_d[0] = d0; b_d[1] = d1; b_d[2] = d2; b_d[3] = d3;
  endtask

  task automatic test_reset();
    idle_inputs();
    b_rst = 1;
    drive(); finish_cycle();
    drive(); finish_cycle();
    b_rst = 0;
    drive();
    checks++; if (bus.write_wen !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", bus.write_wen); end
    checks++; if (bus.write_cnt !== 5'b00001) begin failures++; $display("FAIL reset_cnt got=%b exp=00001", bus.write_cnt); end
    checks++; if (bus.write_start !== 5'b10000) begin failures++; $display("FAIL reset_start got=%b exp=10000", bus.write_start); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready); end
    checks++; if ({bus.write_thread, bus.write_data3, bus.write_data2, bus.write_data1, bus.write_data0} !== '0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {bus.write_data3, bus.write_data2, bus.write_data1, bus.write_data0});
    end
    finish_cycle();
  endtask

  task automatic test_sparse_capture();
    idle_inputs();
    offer(0, 4'b1011, 'hD44D, 'hC33C, 'hB22B, 'hA11A);
    drive();
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL sparse_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.write_wen !== 1'b0) begin failures++; $display("FAIL sparse_latency got=%b exp=0", bus.write_wen); end
    finish_cycle();
    b_v = 0;
    drive();
    checks++; if ({bus.write_wen, bus.write_thread} !== 2'b10) begin failures++; $display("FAIL sparse_wen_thr got=%b exp=10", {bus.write_wen, bus.write_thread}); end
    checks++; if ({bus.write_cnt, bus.write_start} !== 10'b01000_00010) begin
      failures++; $display("FAIL sparse_cnt_start got=%b_%b exp=01000_00010", bus.write_cnt, bus.write_start);
    end
    checks++; if ({bus.write_data3, bus.write_data2, bus.write_data1, bus.write_data0} !== {16'hD44D, 16'hB22B, 16'hA11A, 16'h0000}) begin
      failures++; $display("FAIL sparse_data got=%h_%h_%h_%h exp=d44d_b22b_a11a_0000", bus.write_data3, bus.write_data2, bus.write_data1, bus.write_data0);
    end
    finish_cycle();
    drive();
    checks++; if (bus.write_wen !== 1'b0) begin failures++; $display("FAIL sparse_drained got=%b exp=0", bus.write_wen); end
    finish_cycle();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    offer(0, 4'b1111, 'h0404, 'h0303, 'h0202, 'h0101);
    drive(); finish_cycle();
    offer(0, 4'b0001, 'h9999, 'h8888, 'h7777, 'h5555);
    b_dfs = 1;
    for (int c = 0; c < 3; c++) begin
      drive();
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0", c, bus.in_ready); end
      checks++; if ({bus.write_wen, bus.write_cnt, bus.write_start, bus.write_data3, bus.write_data0} !== {1'b1, 5'b10000, 5'b00001, 16'h0404, 16'h0101}) begin
        failures++; $display("FAIL bp_stable[%0d] got=%b_%b_%b_%h_%h", c, bus.write_wen, bus.write_cnt, bus.write_start, bus.write_data3, bus.write_data0);
      end
      finish_cycle();
    end
    b_dfs = 0;
    drive();
    checks++; if ({bus.in_ready, bus.write_wen} !== 2'b11) begin failures++; $display("FAIL bp_release got=%b exp=11", {bus.in_ready, bus.write_wen}); end
    finish_cycle();
    b_v = 0;
    drive();
    checks++; if ({bus.write_wen, bus.write_cnt, bus.write_start, bus.write_data3, bus.write_data0} !== {1'b1, 5'b00010, 5'b01000, 16'h5555, 16'h0000}) begin
      failures++; $display("FAIL bp_second got=%b_%b_%b_%h_%h", bus.write_wen, bus.write_cnt, bus.write_start, bus.write_data3, bus.write_data0);
    end
    finish_cycle();
    // a reset arriving while a slot is stalled throws the slot away
    offer(1, 4'b0110, 'h1, 'h2, 'h3, 'h4);
    b_dfs = 1;
    drive(); finish_cycle();
    b_v = 0; b_rst = 1;
    drive(); finish_cycle();
    b_rst = 0;
    drive();
    checks++; if ({bus.write_wen, bus.write_cnt} !== 6'b0_00001) begin failures++; $display("FAIL bp_reset_discard got=%b_%b exp=0_00001", bus.write_wen, bus.write_cnt); end
    finish_cycle();
  endtask

  task automatic test_arbitration();
    idle_inputs();
    b_rst = 1; drive(); finish_cycle(); b_rst = 0;
    b_fs = 1;
    offer(1, 4'b0001, 'h0, 'h0, 'h0, 'h1111); drive(); finish_cycle();
    offer(0, 4'b0001, 'h0, 'h0, 'h0, 'h2222); drive(); finish_cycle();
    b_fs = 0; b_v = 0;
    drive();
    checks++; if ({bus.write_wen, bus.write_thread, bus.write_data3} !== {2'b10, 16'h2222}) begin failures++; $display("FAIL arb_first got=%b%b_%h exp=10_2222", bus.write_wen, bus.write_thread, bus.write_data3); end
    finish_cycle(); drive();
    checks++; if ({bus.write_wen, bus.write_thread, bus.write_data3} !== {2'b11, 16'h1111}) begin failures++; $display("FAIL arb_second got=%b%b_%h exp=11_1111", bus.write_wen, bus.write_thread, bus.write_data3); end
    finish_cycle();
    b_fs = 1;
    offer(0, 4'b0001, 'h0, 'h0, 'h0, 'h3333); drive(); finish_cycle();
    offer(1, 4'b0001, 'h0, 'h0, 'h0, 'h4444); drive(); finish_cycle();
    b_fs = 0; b_v = 0;
    drive();
    checks++; if ({bus.write_wen, bus.write_thread, bus.write_data3} !== {2'b10, 16'h3333}) begin failures++; $display("FAIL arb_refill_first got=%b%b_%h exp=10_3333", bus.write_wen, bus.write_thread, bus.write_data3); end
    finish_cycle(); drive();
    checks++; if ({bus.write_wen, bus.write_thread, bus.write_data3} !== {2'b11, 16'h4444}) begin failures++; $display("FAIL arb_refill_second got=%b%b_%h exp=11_4444", bus.write_wen, bus.write_thread, bus.write_data3); end
    finish_cycle();
  endtask

  task automatic test_flush();
    idle_inputs();
    offer(0, 4'b1000, 'h0, 'h0, 'h0, 'h5A5A); drive(); finish_cycle();
    b_v = 0; drive(); finish_cycle();
    b_fs = 1;
    offer(1, 4'b0100, 'h0, 'h6B6B, 'h0, 'h0); drive(); finish_cycle();
    offer(0, 4'b0010, 'h0, 'h0, 'h7C7C, 'h0); drive(); finish_cycle();
    b_v = 0; b_fs = 0; b_ex = 1; b_exthr = 1;
    drive();
    checks++; if ({bus.write_wen, bus.write_thread} !== 2'b01) begin failures++; $display("FAIL flush_kill got=%b exp=01", {bus.write_wen, bus.write_thread}); end
    finish_cycle();
    b_ex = 0;
    drive();
    checks++; if ({bus.write_wen, bus.write_thread, bus.write_data3} !== {2'b10, 16'h7C7C}) begin failures++; $display("FAIL flush_other got=%b%b_%h exp=10_7c7c", bus.write_wen, bus.write_thread, bus.write_data3); end
    finish_cycle();
    drive();
    checks++; if (bus.write_wen !== 1'b0) begin failures++; $display("FAIL flush_dropped got=%b exp=0", bus.write_wen); end
    finish_cycle();
  endtask

  task automatic test_empty_bundle();
    idle_inputs();
    offer(1, 4'b0000, 'h1, 'h2, 'h3, 'h4);
    drive();
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL empty_ready got=%b exp=1", bus.in_ready); end
    finish_cycle();
    b_v = 0; b_thr = 1; b_dfs = 1;
    drive();
    checks++; if ({bus.write_wen, bus.write_cnt, bus.in_ready} !== 7'b0_00001_1) begin
      failures++; $display("FAIL empty_dropped got=%b_%b_%b exp=0_00001_1", bus.write_wen, bus.write_cnt, bus.in_ready);
    end
    finish_cycle();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int c = 0; c < 500; c++) begin
      b_v     = ($urandom_range(0, 3) != 0);
      b_thr   = 1'($urandom);
      b_m     = 4'($urandom);
      b_fs    = ($urandom_range(0, 3) == 0);
      b_dfs   = ($urandom_range(0, 3) == 0);
      b_ex    = ($urandom_range(0, 9) == 0);
      b_exthr = 1'($urandom);
      b_rst   = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < 4; i++) b_d[i] = DW'($urandom);
      drive();
      checks++; if (bus.in_ready !== e_ready) begin failures++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", c, bus.in_ready, e_ready); end
      checks++; if ({bus.write_wen, bus.write_thread} !== {e_wen, e_thr}) begin failures++; $display("FAIL rnd_wen_thr[%0d] got=%b%b exp=%b%b", c, bus.write_wen, bus.write_thread, e_wen, e_thr); end
      checks++; if ({bus.write_cnt, bus.write_start} !== {e_cnt, e_start}) begin failures++; $display("FAIL rnd_cnt_start[%0d] got=%b_%b exp=%b_%b", c, bus.write_cnt, bus.write_start, e_cnt, e_start); end
      checks++; if ({bus.write_data3, bus.write_data2, bus.write_data1, bus.write_data0} !== {e_d[3], e_d[2], e_d[1], e_d[0]}) begin
        failures++; $display("FAIL rnd_data[%0d] got=%h_%h_%h_%h exp=%h_%h_%h_%h", c, bus.write_data3, bus.write_data2, bus.write_data1, bus.write_data0, e_d[3], e_d[2], e_d[1], e_d[0]);
      end
      finish_cycle();
    end
  endtask

  initial begin
    m_v[0] = 0; m_v[1] = 0; m_rr = 0;
    m_n[0] = 0; m_n[1] = 0;
    test_reset();
    test_sparse_capture();
    test_backpressure();
    test_arbitration();
    test_flush();
    test_empty_bundle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
